// File: rtl/weight1_update_ctrl_pkg.sv
// Shared definitions for the layer-1 weight update controller: FSM states,
// default network dimensions and the datapath write latency.
package weight1_update_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ARM    = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_NEXT   = 3'd5
    } state_t;

    localparam int unsigned DEF_NPIXEL  = 784;
    localparam int unsigned DEF_NHIDDEN = 32;

    // Cycles from a weight read to its write-back (EXEC register plus adder)
    localparam int unsigned WR_LATENCY  = 2;

endpackage

// File: rtl/wupd_delay.sv
// Valid/data delay line of DEPTH register stages with synchronous flush;
// aligns read-side strobes and addresses with the datapath write-back.
module wupd_delay
    import weight1_update_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = WR_LATENCY,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned DW = DEPTH * WIDTH;

    logic [DEPTH-1:0] r_vld;
    logic [DW-1:0]    r_data;

    // Stage 0 sits in the low bits; each edge shifts everything one stage up
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_vld  <= '0;
            r_data <= '0;
        end else if (flush) begin
            r_vld  <= '0;
            r_data <= '0;
        end else begin
            r_vld  <= DEPTH'({r_vld, in_vld});
            r_data <= DW'({r_data, in_data});
        end
    end

    assign out_vld  = r_vld[DEPTH-1];
    assign out_data = r_data[DW-1 -: WIDTH];

endmodule

// File: rtl/weight1_update_ctrl.sv
// Layer-1 weight update sequencer: walks every hidden neuron, arms the delta
// datapath and streams pixel/weight addresses. Optional bias writes: WUPD_BIAS_EN.
module weight1_update_ctrl
    import weight1_update_ctrl_pkg::*;
#(
    parameter int unsigned NWBITS     = 16,
    parameter int unsigned NPIXEL     = DEF_NPIXEL,
    parameter int unsigned NHIDDEN    = DEF_NHIDDEN,
    parameter int unsigned COUNT_BIT1 = 10,
    parameter int unsigned HID_BITS   = 5
) (
    input  logic                           clk,
    input  logic                           reset_b,
    input  logic                           start,
    input  logic                           abort,
    output logic                           busy,
    output logic                           done,
    output logic [HID_BITS-1:0]            deriv_rd_addr,
    output logic                           start_state6,
    output logic [COUNT_BIT1-1:0]          pixel_addr,
    output logic [HID_BITS+COUNT_BIT1-1:0] w_rd_addr,
    output logic                           w_wr_en,
    output logic [HID_BITS+COUNT_BIT1-1:0] w_wr_addr,
    output logic                           b_wr_en,
    output logic [HID_BITS-1:0]            b_wr_addr
);

    localparam int unsigned AW = HID_BITS + COUNT_BIT1;
    localparam logic [COUNT_BIT1-1:0] LAST_PIX = COUNT_BIT1'(NPIXEL - 1);
    localparam logic [HID_BITS-1:0]   LAST_HID = HID_BITS'(NHIDDEN - 1);

    // Reject parameter sets whose counters cannot reach the last index
    generate
        if (NWBITS == 0 || NPIXEL < 1 || NHIDDEN < 1 ||
            NPIXEL > (1 << COUNT_BIT1) || NHIDDEN > (1 << HID_BITS)) begin : g_bad_cfg
            $error("weight1_update_ctrl: inconsistent parameter set");
        end
    endgenerate

    state_t                r_state;
    logic [HID_BITS-1:0]   r_neuron;
    logic [COUNT_BIT1-1:0] r_pix;
    logic                  r_drain;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_start_state6;

    logic                  w_rd_vld;
    logic [AW-1:0]         w_rd_addr_int;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state        <= S_IDLE;
            r_neuron       <= '0;
            r_pix          <= '0;
            r_drain        <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_start_state6 <= 1'b0;
        end else begin
            r_done         <= 1'b0;
            r_start_state6 <= 1'b0;
            if (abort) begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_neuron <= '0;
                r_pix    <= '0;
                r_drain  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_neuron <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        // Derivative RAM read completes; arm pulse lands in ARM
                        r_start_state6 <= 1'b1;
                        r_state        <= S_ARM;
                    end
                    S_ARM: begin
                        r_pix   <= '0;
                        r_state <= S_STREAM;
                    end
                    S_STREAM: begin
                        if (r_pix == LAST_PIX) begin
                            r_drain <= 1'b0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_pix <= r_pix + COUNT_BIT1'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (r_drain) begin
                            r_state <= S_NEXT;
                            r_done  <= (r_neuron == LAST_HID);
                        end else begin
                            r_drain <= 1'b1;
                        end
                    end
                    S_NEXT: begin
                        if (r_neuron == LAST_HID) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_neuron <= r_neuron + HID_BITS'(1);
                            r_state  <= S_LOAD;
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign w_rd_vld      = (r_state == S_STREAM);
    assign w_rd_addr_int = {r_neuron, r_pix};

    // Write strobe trails each streamed read by the datapath latency
    wupd_delay #(
        .DEPTH (WR_LATENCY),
        .WIDTH (AW)
    ) u_wr_dly (
        .clk      (clk),
        .reset_b  (reset_b),
        .flush    (abort),
        .in_vld   (w_rd_vld),
        .in_data  (w_rd_addr_int),
        .out_vld  (w_wr_en),
        .out_data (w_wr_addr)
    );

`ifdef WUPD_BIAS_EN
    // Bias write follows the arm pulse by the delta_bias latency
    wupd_delay #(
        .DEPTH (WR_LATENCY),
        .WIDTH (HID_BITS)
    ) u_bias_dly (
        .clk      (clk),
        .reset_b  (reset_b),
        .flush    (abort),
        .in_vld   (r_start_state6),
        .in_data  (r_neuron),
        .out_vld  (b_wr_en),
        .out_data (b_wr_addr)
    );
`else
    assign b_wr_en   = 1'b0;
    assign b_wr_addr = '0;
`endif

    assign busy          = r_busy;
    assign done          = r_done;
    assign start_state6  = r_start_state6;
    assign deriv_rd_addr = r_neuron;
    assign pixel_addr    = r_pix;
    assign w_rd_addr     = w_rd_addr_int;

endmodule

// File: tb/tb_weight1_update_ctrl.sv
// Scoreboard bench for weight1_update_ctrl: a cycle-offset model of each run
// fills an event queue; a negedge monitor pops and compares DUT strobes.
module tb_weight1_update_ctrl;

    localparam int NH = 2;
    localparam int NP = 4;
    localparam int CB = 4;
    localparam int HB = 2;
    localparam int P  = NP + 5;
    localparam int RUN = NH * P;

    localparam int K_WR   = 0;
    localparam int K_S6   = 1;
    localparam int K_BIAS = 2;
    localparam int K_DONE = 3;
    localparam int K_RD   = 4;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, start_state6, w_wr_en, b_wr_en;
    logic [HB-1:0]    deriv_rd_addr, b_wr_addr;
    logic [CB-1:0]    pixel_addr;
    logic [HB+CB-1:0] w_rd_addr, w_wr_addr;

    weight1_update_ctrl #(
        .NWBITS     (16),
        .NPIXEL     (NP),
        .NHIDDEN    (NH),
        .COUNT_BIT1 (CB),
        .HID_BITS   (HB)
    ) dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .deriv_rd_addr (deriv_rd_addr),
        .start_state6  (start_state6),
        .pixel_addr    (pixel_addr),
        .w_rd_addr     (w_rd_addr),
        .w_wr_en       (w_wr_en),
        .w_wr_addr     (w_wr_addr),
        .b_wr_en       (b_wr_en),
        .b_wr_addr     (b_wr_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    int exp_lo  = 1;
    int exp_hi  = 0;

    function automatic int find_ev(input int k);
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].kind == k) return i;
        return -1;
    endfunction

    task automatic push(input int k, input int c, input int v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic cancel_after(input int c);
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].cyc > c) sb.delete(i);
    endtask

    task automatic check_ev(input int k, input string nm, input int act);
        int i;
        i = find_ev(k);
        n_tests++;
        if (i < 0) begin
            n_fail++;
            $display("FAIL %s: unexpected strobe at cycle %0d value %0d, required none", nm, cyc, act);
        end else begin
            if (sb[i].cyc != cyc || sb[i].val != act) begin
                n_fail++;
                $display("FAIL %s: got value %0d at cycle %0d, required value %0d at cycle %0d",
                         nm, act, cyc, sb[i].val, sb[i].cyc);
            end
            sb.delete(i);
        end
    endtask

    // Run model: neuron n occupies offsets n*P+1 .. n*P+P after the start cycle
    task automatic push_run(input int c0);
        int base;
        int a;
        for (int n = 0; n < NH; n++) begin
            base = c0 + n * P;
            push(K_S6, base + 2, n);
`ifdef WUPD_BIAS_EN
            push(K_BIAS, base + 4, n);
`endif
            for (int p = 0; p < NP; p++) begin
                a = n * (1 << CB) + p;
                push(K_RD, base + 3 + p, a);
                push(K_WR, base + 5 + p, a);
            end
        end
        push(K_DONE, c0 + RUN, NH - 1);
        exp_lo = c0 + 1;
        exp_hi = c0 + RUN;
    endtask

    always @(negedge clk) begin : mon
        bit eb;
        int ri;
        eb = (cyc >= exp_lo && cyc <= exp_hi);
        n_tests++;
        if (busy !== eb) begin
            n_fail++;
            $display("FAIL busy: cycle %0d got %b required %b", cyc, busy, eb);
        end
        if (w_wr_en === 1'b1)      check_ev(K_WR, "w_wr_addr", int'(w_wr_addr));
        if (start_state6 === 1'b1) check_ev(K_S6, "start_state6/deriv_rd_addr", int'(deriv_rd_addr));
        if (b_wr_en === 1'b1)      check_ev(K_BIAS, "b_wr_addr", int'(b_wr_addr));
        if (done === 1'b1)         check_ev(K_DONE, "done/deriv_rd_addr", int'(deriv_rd_addr));
        ri = find_ev(K_RD);
        if (ri >= 0 && sb[ri].cyc == cyc) begin
            n_tests++;
            if (int'(w_rd_addr) != sb[ri].val || int'(pixel_addr) != sb[ri].val % (1 << CB)) begin
                n_fail++;
                $display("FAIL rd_addr: cycle %0d got w_rd_addr %0d pixel_addr %0d required %0d / %0d",
                         cyc, w_rd_addr, pixel_addr, sb[ri].val, sb[ri].val % (1 << CB));
            end
            sb.delete(ri);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        n_tests++;
        if ({busy, done, start_state6, w_wr_en, b_wr_en, deriv_rd_addr, pixel_addr,
             w_rd_addr, w_wr_addr, b_wr_addr} !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs busy=%b done=%b s6=%b wr=%b bwr=%b deriv=%0d pix=%0d rd=%0d wa=%0d ba=%0d, required all 0",
                     nm, busy, done, start_state6, w_wr_en, b_wr_en, deriv_rd_addr, pixel_addr,
                     w_rd_addr, w_wr_addr, b_wr_addr);
        end
    endtask

    task automatic begin_run(input bit ab, output int c0);
        c0 = cyc;
        start = 1'b1;
        abort = ab;
        if (!ab) push_run(c0);
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_idle();
        while (cyc <= exp_hi + 3) tick();
    endtask

    task automatic do_abort();
        cancel_after(cyc);
        if (exp_hi > cyc) exp_hi = cyc;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic do_reset();
        int rc;
        rc = cyc;
        cancel_after(rc - 1);
        if (exp_hi > rc - 1) exp_hi = rc - 1;
        reset_b = 1'b0;
        #1;
        check_zero("reset_mid_run");
        tick();
        reset_b = 1'b1;
    endtask

    initial begin
        int c0;
        int mode;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset_b = 1'b1;
        repeat (2) tick();

        // Plain full run
        begin_run(1'b0, c0);
        wait_idle();

        // start re-pulsed while busy must not restart the run
        begin_run(1'b0, c0);
        while (cyc < c0 + RUN - 1) begin
            start = ($urandom_range(0, 2) == 0);
            tick();
        end
        start = 1'b0;
        wait_idle();

        // abort while streaming neuron 1
        begin_run(1'b0, c0);
        run_to(c0 + P + 3 + $urandom_range(0, NP - 1));
        do_abort();
        repeat (RUN) tick();

        // reset pulse during neuron 0 drain, then a fresh full run
        begin_run(1'b0, c0);
        run_to(c0 + NP + 3 + $urandom_range(0, 1));
        do_reset();
        repeat (3) tick();
        begin_run(1'b0, c0);
        wait_idle();

        // Randomised mix of full runs, aborts, start+abort, resets
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 4)) tick();
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin
                    begin_run(1'b0, c0);
                    wait_idle();
                end
                1: begin
                    begin_run(1'b0, c0);
                    run_to(c0 + $urandom_range(1, RUN));
                    do_abort();
                    repeat (P) tick();
                end
                2: begin
                    begin_run(1'b1, c0);
                    repeat (P) tick();
                end
                default: begin
                    begin_run(1'b0, c0);
                    run_to(c0 + $urandom_range(1, RUN));
                    do_reset();
                    repeat (P) tick();
                end
            endcase
        end

        repeat (4) tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: %0d expected strobes never seen, first kind %0d at cycle %0d",
                     sb.size(), sb[0].kind, sb[0].cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
